// File: rtl/mtimer_pkg.sv
// Shared definitions for the memory-mapped machine timer.
//   - Register offsets within the 5-word window.
//   - CTRL bit positions.
//   - ctrl_t: the CTRL register as a packed struct.
//   - reg_sel_e: decoded register target of a bus access.
package mtimer_pkg;

  localparam logic [4:0] OFF_MTIME_LO    = 5'h00;
  localparam logic [4:0] OFF_MTIME_HI    = 5'h04;
  localparam logic [4:0] OFF_MTIMECMP_LO = 5'h08;
  localparam logic [4:0] OFF_MTIMECMP_HI = 5'h0C;
  localparam logic [4:0] OFF_CTRL        = 5'h10;

  // Window size in bytes: five 32-bit words.
  localparam int unsigned WIN_BYTES = 20;

  localparam int unsigned CTRL_CNT_EN_BIT = 0;
  localparam int unsigned CTRL_IRQ_EN_BIT = 1;
  localparam int unsigned CTRL_PRESC_LSB  = 8;

  // Storage width of the PRESC field. PRESC_W on the top may be narrower;
  // bits at or above PRESC_W are then held at zero.
  localparam int unsigned CTRL_PRESC_W = 8;

  typedef struct packed {
    logic [CTRL_PRESC_W-1:0] presc;
    logic                    irq_en;
    logic                    cnt_en;
  } ctrl_t;

  typedef enum logic [2:0] {
    REG_MTIME_LO,
    REG_MTIME_HI,
    REG_MTIMECMP_LO,
    REG_MTIMECMP_HI,
    REG_CTRL,
    REG_NONE
  } reg_sel_e;

endpackage

// File: rtl/mtimer_csr_irq_presc.sv
// Prescaler for the machine timer.
// This is the mtimer_presc block.
// It counts 0..reload while enabled and pulses tick on the cycle it sits at reload.
// Ports:
//   clk    in   system clock
//   rst    in   asynchronous reset, active-low
//   en     in   count enable; when low the count is frozen
//   clr    in   synchronous clear, takes priority over counting
//   reload in   terminal count (PRESC)
//   tick   out  high on the cycle the count equals reload while enabled
module mtimer_presc #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] reload,
  output logic         tick
);

  logic [W-1:0] presc_cnt_q;
  logic [W-1:0] presc_cnt_d;

  assign tick = en && (presc_cnt_q == reload);

  always_comb begin
    presc_cnt_d = presc_cnt_q;
    if (clr) begin
      presc_cnt_d = '0;
    end else if (en) begin
      presc_cnt_d = tick ? '0 : presc_cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_cnt_q <= '0;
    end else begin
      presc_cnt_q <= presc_cnt_d;
    end
  end

endmodule

// File: rtl/mtimer_csr_irq.sv
// RISC-V machine timer (mtime/mtimecmp) slaved to the data-memory bus.
// The block drives mip.MTIP into the CSR stage.
// Ports:
//   clk         in   system clock, all state on rising edge
//   rst         in   asynchronous reset, active-low
//   bus_addr    in   byte address from LSU
//   bus_wdata   in   store data
//   bus_we      in   store strobe
//   bus_re      in   load strobe
//   bus_rdata   out  load data, registered; holds when bus_rvalid=0
//   bus_rvalid  out  one-cycle pulse one cycle after an accepted load
//   bus_err     out  one-cycle pulse one cycle after a bad or colliding access
//   timer_irq   out  level interrupt: IRQ_EN & (mtime >= mtimecmp), registered
module mtimer_csr_irq
  import mtimer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int unsigned PRESC_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wdata,
  input  logic        bus_we,
  input  logic        bus_re,
  output logic [31:0] bus_rdata,
  output logic        bus_rvalid,
  output logic        bus_err,
  output logic        timer_irq
);

  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  ctrl_t       ctrl_q, ctrl_d;
  logic [31:0] shadow_hi_q, shadow_hi_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rvalid_q, rvalid_d;
  logic        err_q, err_d;
  logic        irq_q, irq_d;

  logic [31:0] offset;
  logic        addr_ok;
  reg_sel_e    sel;
  logic        wr_en;
  logic        rd_en;
  logic        ctrl_wr;
  logic        tick;
  logic [31:0] ctrl_rd;

  // BASE_ADDR is word-aligned, so alignment can be checked on the raw address.
  assign offset  = bus_addr - BASE_ADDR;
  assign addr_ok = (bus_addr[1:0] == 2'b00) && (offset < WIN_BYTES);

  always_comb begin
    sel = REG_NONE;
    if (addr_ok) begin
      case (offset[4:0])
        OFF_MTIME_LO:    sel = REG_MTIME_LO;
        OFF_MTIME_HI:    sel = REG_MTIME_HI;
        OFF_MTIMECMP_LO: sel = REG_MTIMECMP_LO;
        OFF_MTIMECMP_HI: sel = REG_MTIMECMP_HI;
        OFF_CTRL:        sel = REG_CTRL;
        default:         sel = REG_NONE;
      endcase
    end
  end

  // A simultaneous store and load performs the store and drops the load.
  assign wr_en   = bus_we && addr_ok;
  assign rd_en   = bus_re && !bus_we;
  assign ctrl_wr = wr_en && (sel == REG_CTRL);

  mtimer_presc #(
    .W(CTRL_PRESC_W)
  ) u_presc (
    .clk   (clk),
    .rst   (rst),
    .en    (ctrl_q.cnt_en),
    .clr   (ctrl_wr),
    .reload(ctrl_q.presc),
    .tick  (tick)
  );

  always_comb begin
    ctrl_rd = '0;
    ctrl_rd[CTRL_CNT_EN_BIT] = ctrl_q.cnt_en;
    ctrl_rd[CTRL_IRQ_EN_BIT] = ctrl_q.irq_en;
    ctrl_rd[CTRL_PRESC_LSB +: CTRL_PRESC_W] = ctrl_q.presc;
  end

  always_comb begin
    mtime_d     = mtime_q + 64'(tick);
    mtimecmp_d  = mtimecmp_q;
    ctrl_d      = ctrl_q;
    shadow_hi_d = shadow_hi_q;
    rdata_d     = rdata_q;
    rvalid_d    = rd_en;
    err_d       = (bus_we || bus_re) && (!addr_ok || (bus_we && bus_re));
    // Compare on the registered values, so the line follows the compare by one cycle.
    irq_d       = ctrl_q.irq_en && (mtime_q >= mtimecmp_q);

    // A half-write overrides the increment; the other half keeps its
    // pre-increment value, so no carry crosses between halves.
    if (wr_en) begin
      case (sel)
        REG_MTIME_LO:    mtime_d = {mtime_q[63:32], bus_wdata};
        REG_MTIME_HI:    mtime_d = {bus_wdata, mtime_q[31:0]};
        REG_MTIMECMP_LO: mtimecmp_d[31:0]  = bus_wdata;
        REG_MTIMECMP_HI: mtimecmp_d[63:32] = bus_wdata;
        REG_CTRL: begin
          ctrl_d.cnt_en = bus_wdata[CTRL_CNT_EN_BIT];
          ctrl_d.irq_en = bus_wdata[CTRL_IRQ_EN_BIT];
          for (int unsigned i = 0; i < CTRL_PRESC_W; i++) begin
            ctrl_d.presc[i] = (i < PRESC_W) ? bus_wdata[CTRL_PRESC_LSB + i] : 1'b0;
          end
        end
        default: ;
      endcase
    end

    // MTIME_LO snapshots the high half so a LO-then-HI pair is consistent.
    if (rd_en) begin
      case (sel)
        REG_MTIME_LO: begin
          rdata_d     = mtime_q[31:0];
          shadow_hi_d = mtime_q[63:32];
        end
        REG_MTIME_HI:    rdata_d = shadow_hi_q;
        REG_MTIMECMP_LO: rdata_d = mtimecmp_q[31:0];
        REG_MTIMECMP_HI: rdata_d = mtimecmp_q[63:32];
        REG_CTRL:        rdata_d = ctrl_rd;
        default:         rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mtime_q     <= '0;
      mtimecmp_q  <= '1;
      ctrl_q      <= '0;
      shadow_hi_q <= '0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
      err_q       <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      ctrl_q      <= ctrl_d;
      shadow_hi_q <= shadow_hi_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
      err_q       <= err_d;
      irq_q       <= irq_d;
    end
  end

  assign bus_rdata  = rdata_q;
  assign bus_rvalid = rvalid_q;
  assign bus_err    = err_q;
  assign timer_irq  = irq_q;

endmodule

// File: tb/tb_mtimer_csr_irq.sv
// Testbench for mtimer_csr_irq: a table of bus vectors, hand sequences for
// the multi-cycle cases, and randomized traffic against a reference model.
module tb_mtimer_csr_irq;

  localparam logic [31:0] BASE   = 32'h0200_0000;
  localparam logic [31:0] A_LO   = BASE;
  localparam logic [31:0] A_HI   = BASE + 32'd4;
  localparam logic [31:0] A_CLO  = BASE + 32'd8;
  localparam logic [31:0] A_CHI  = BASE + 32'd12;
  localparam logic [31:0] A_CTRL = BASE + 32'd16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] bus_addr = '0;
  logic [31:0] bus_wdata = '0;
  logic        bus_we = 1'b0;
  logic        bus_re = 1'b0;
  logic [31:0] bus_rdata;
  logic        bus_rvalid;
  logic        bus_err;
  logic        timer_irq;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mtimer_csr_irq #(
    .BASE_ADDR(BASE),
    .PRESC_W  (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_we    (bus_we),
    .bus_re    (bus_re),
    .bus_rdata (bus_rdata),
    .bus_rvalid(bus_rvalid),
    .bus_err   (bus_err),
    .timer_irq (timer_irq)
  );

  // ---------------- reference model ----------------
  logic [63:0] m_mtime, m_cmp;
  logic        m_cnt_en, m_irq_en;
  int unsigned m_presc, m_pcnt;
  logic [31:0] m_shadow, m_rdata;
  logic        m_rvalid, m_err, m_irq;

  function automatic void model_reset();
    m_mtime  = 64'd0;
    m_cmp    = 64'hFFFF_FFFF_FFFF_FFFF;
    m_cnt_en = 1'b0;
    m_irq_en = 1'b0;
    m_presc  = 0;
    m_pcnt   = 0;
    m_shadow = 32'd0;
    m_rdata  = 32'd0;
    m_rvalid = 1'b0;
    m_err    = 1'b0;
    m_irq    = 1'b0;
  endfunction

  // One clock edge of the model, using the bus inputs present at that edge.
  function automatic void model_step();
    logic [63:0] nt, ncmp;
    logic        ncen, nien;
    int unsigned npresc, npcnt;
    logic [31:0] off;
    logic        good, inc;
    logic [7:0]  pb;
    inc    = m_cnt_en && (m_pcnt == m_presc);
    npcnt  = !m_cnt_en ? m_pcnt : (inc ? 0 : m_pcnt + 1);
    nt     = m_mtime + (inc ? 64'd1 : 64'd0);
    ncmp   = m_cmp;
    ncen   = m_cnt_en;
    nien   = m_irq_en;
    npresc = m_presc;
    off    = bus_addr - BASE;
    good   = (bus_addr % 4 == 0) && (off < 20);
    m_irq  = m_irq_en && (m_mtime >= m_cmp);
    if (bus_we && good) begin
      case (off)
        32'd0:  nt = {m_mtime[63:32], bus_wdata};
        32'd4:  nt = {bus_wdata, m_mtime[31:0]};
        32'd8:  ncmp[31:0] = bus_wdata;
        32'd12: ncmp[63:32] = bus_wdata;
        default: begin
          ncen   = bus_wdata[0];
          nien   = bus_wdata[1];
          npresc = 32'(bus_wdata[15:8]);
          npcnt  = 0;
        end
      endcase
    end
    m_err    = (bus_we || bus_re) && (!good || (bus_we && bus_re));
    m_rvalid = bus_re && !bus_we;
    if (m_rvalid) begin
      if (!good) m_rdata = 32'd0;
      else begin
        case (off)
          32'd0: begin
            m_rdata  = m_mtime[31:0];
            m_shadow = m_mtime[63:32];
          end
          32'd4:  m_rdata = m_shadow;
          32'd8:  m_rdata = m_cmp[31:0];
          32'd12: m_rdata = m_cmp[63:32];
          default: begin
            pb      = m_presc[7:0];
            m_rdata = {16'd0, pb, 6'd0, m_irq_en, m_cnt_en};
          end
        endcase
      end
    end
    m_mtime  = nt;
    m_cmp    = ncmp;
    m_cnt_en = ncen;
    m_irq_en = nien;
    m_presc  = npresc;
    m_pcnt   = npcnt;
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    if (rst) model_step();
    else model_reset();
    #1;
  endtask

  task automatic idle(input int n);
    bus_we = 1'b0;
    bus_re = 1'b0;
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus_we = 1'b1; bus_re = 1'b0; bus_addr = a; bus_wdata = d;
    cyc();
    bus_we = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string nm);
    bus_re = 1'b1; bus_we = 1'b0; bus_addr = a;
    cyc();
    bus_re = 1'b0;
    chk({nm, "_rvalid"}, 64'(bus_rvalid), 64'd1);
    chk(nm, 64'(bus_rdata), 64'(exp));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        we;
    logic        re;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rvalid;
    logic        err;
    logic        irq;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mkv(logic we, logic re, logic [31:0] a, logic [31:0] wd,
                               logic [31:0] rdat, logic rv, logic er, logic iq);
    vec_t v;
    v.we = we; v.re = re; v.addr = a; v.wdata = wd;
    v.rdata = rdat; v.rvalid = rv; v.err = er; v.irq = iq;
    return v;
  endfunction

  task automatic rand_op();
    int unsigned k, r, bits;
    k = $urandom_range(0, 99);
    r = $urandom_range(0, 4);
    bus_we = 1'b0; bus_re = 1'b0;
    bus_addr = BASE + r * 4;
    case (r)
      0, 2:    bus_wdata = $urandom_range(0, 80);
      1, 3:    bus_wdata = $urandom_range(0, 1);
      default: begin
        bits = $urandom_range(0, 3);
        if ($urandom_range(0, 3) != 0) bits = bits | 1;
        bus_wdata = ($urandom_range(0, 3) << 8) | bits;
      end
    endcase
    if (k >= 95) bus_wdata = $urandom;
    if (k < 30) bus_re = 1'b1;
    else if (k < 55) bus_we = 1'b1;
    else if (k < 60) begin bus_we = 1'b1; bus_re = 1'b1; end
    else if (k < 65) begin
      bus_re = 1'b1;
      bus_addr = BASE + 20 + 4 * $urandom_range(0, 8);
    end else if (k < 70) begin
      bus_we = 1'($urandom_range(0, 1));
      bus_re = !bus_we;
      bus_addr = BASE + r * 4 + $urandom_range(1, 3);
    end
  endtask

  initial begin
    model_reset();
    // Reset state
    idle(3);
    chk("rst_rvalid", 64'(bus_rvalid), 64'd0);
    chk("rst_err",    64'(bus_err),    64'd0);
    chk("rst_irq",    64'(timer_irq),  64'd0);
    chk("rst_rdata",  64'(bus_rdata),  64'd0);
    @(negedge clk);
    rst = 1'b1;
    idle(2);

    // Table: reset values, shadow behaviour, bad accesses, collision, irq level
    vt.push_back(mkv(0, 1, A_CHI,  0, 32'hFFFF_FFFF, 1, 0, 0));
    vt.push_back(mkv(0, 1, A_CLO,  0, 32'hFFFF_FFFF, 1, 0, 0));
    vt.push_back(mkv(0, 1, A_LO,   0, 32'h0,         1, 0, 0));
    vt.push_back(mkv(0, 1, A_HI,   0, 32'h0,         1, 0, 0));
    vt.push_back(mkv(0, 1, A_CTRL, 0, 32'h0,         1, 0, 0));
    vt.push_back(mkv(1, 0, A_CLO,  32'h1234, 32'h0,  0, 0, 0));
    vt.push_back(mkv(0, 1, A_CLO,  0, 32'h1234,      1, 0, 0));
    vt.push_back(mkv(1, 0, A_HI,   32'hAB, 32'h1234, 0, 0, 0));
    vt.push_back(mkv(0, 1, A_HI,   0, 32'h0,         1, 0, 0));
    vt.push_back(mkv(0, 1, A_LO,   0, 32'h0,         1, 0, 0));
    vt.push_back(mkv(0, 1, A_HI,   0, 32'hAB,        1, 0, 0));
    vt.push_back(mkv(1, 0, BASE + 32'h14, 32'h55, 32'hAB, 0, 1, 0));
    vt.push_back(mkv(0, 1, BASE + 32'h02, 0, 32'h0,  1, 1, 0));
    vt.push_back(mkv(1, 1, A_CHI,  32'h5, 32'h0,     0, 1, 0));
    vt.push_back(mkv(0, 1, A_CHI,  0, 32'h5,         1, 0, 0));
    vt.push_back(mkv(0, 1, A_CLO,  0, 32'h1234,      1, 0, 0));
    vt.push_back(mkv(1, 0, A_CTRL, 32'hFFFF_FF02, 32'h1234, 0, 0, 0));
    vt.push_back(mkv(0, 1, A_CTRL, 0, 32'h0000_FF02, 1, 0, 1));
    vt.push_back(mkv(1, 0, A_CHI,  32'hFFFF_FFFF, 32'hFF02, 0, 0, 1));
    vt.push_back(mkv(0, 0, A_CHI,  0, 32'hFF02,      0, 0, 0));
    foreach (vt[i]) begin
      bus_we = vt[i].we; bus_re = vt[i].re;
      bus_addr = vt[i].addr; bus_wdata = vt[i].wdata;
      cyc();
      chk($sformatf("tbl%0d_rvalid", i), 64'(bus_rvalid), 64'(vt[i].rvalid));
      chk($sformatf("tbl%0d_err", i),    64'(bus_err),    64'(vt[i].err));
      chk($sformatf("tbl%0d_irq", i),    64'(timer_irq),  64'(vt[i].irq));
      chk($sformatf("tbl%0d_rdata", i),  64'(bus_rdata),  64'(vt[i].rdata));
    end
    idle(1);

    // Count rate, PRESC=0 then PRESC=3
    wr(A_CTRL, 0); wr(A_LO, 0); wr(A_HI, 0); wr(A_CTRL, 32'h1);
    idle(10);
    rd(A_LO, 32'd10, "rate_p0");
    wr(A_CTRL, 0); wr(A_LO, 0); wr(A_HI, 0); wr(A_CTRL, 32'h301);
    idle(40);
    rd(A_LO, 32'd10, "rate_p3");

    // Carry into the high half and LO/HI snapshot
    wr(A_CTRL, 0); wr(A_LO, 32'hFFFF_FFFE); wr(A_HI, 0); wr(A_CTRL, 32'h1);
    idle(3);
    rd(A_LO, 32'd1, "carry_lo");
    rd(A_HI, 32'd1, "carry_hi");
    wr(A_CTRL, 0); wr(A_LO, 32'hFFFF_FFFD); wr(A_HI, 32'd7); wr(A_CTRL, 32'h1);
    rd(A_LO, 32'hFFFF_FFFD, "snap_lo");
    idle(3);
    rd(A_HI, 32'd7, "snap_hi");

    // 64-bit wrap
    wr(A_CTRL, 0); wr(A_LO, 32'hFFFF_FFFF); wr(A_HI, 32'hFFFF_FFFF); wr(A_CTRL, 32'h1);
    idle(1);
    rd(A_LO, 32'd0, "wrap_lo");
    rd(A_HI, 32'd0, "wrap_hi");

    // Interrupt timing and deassertion
    wr(A_CTRL, 0); wr(A_LO, 0); wr(A_HI, 0); wr(A_CHI, 0); wr(A_CLO, 32'd20);
    wr(A_CTRL, 32'h3);
    for (int k = 1; k <= 21; k++) begin
      idle(1);
      chk($sformatf("irq_rise_k%0d", k), 64'(timer_irq), (k >= 21) ? 64'd1 : 64'd0);
    end
    wr(A_CLO, 32'd1000);
    chk("irq_cmpwr_edge", 64'(timer_irq), 64'd1);
    idle(1);
    chk("irq_dropped", 64'(timer_irq), 64'd0);
    wr(A_CLO, 32'd20);
    idle(1);
    chk("irq_rearmed", 64'(timer_irq), 64'd1);

    // Asynchronous reset with irq high and a read in flight
    bus_re = 1'b1; bus_addr = A_LO;
    cyc();
    chk("pre_rst_rvalid", 64'(bus_rvalid), 64'd1);
    #3;
    rst = 1'b0;
    #1;
    model_reset();
    chk("async_rst_rvalid", 64'(bus_rvalid), 64'd0);
    chk("async_rst_irq",    64'(timer_irq),  64'd0);
    chk("async_rst_rdata",  64'(bus_rdata),  64'd0);
    cyc();
    chk("rst_hold_rvalid", 64'(bus_rvalid), 64'd0);
    bus_re = 1'b0;
    rst = 1'b1;
    idle(1);
    rd(A_LO,  32'd0,         "post_rst_mtime");
    rd(A_CHI, 32'hFFFF_FFFF, "post_rst_cmp");

    // Randomized traffic against the model
    for (int n = 0; n < 500; n++) begin
      rand_op();
      cyc();
      chk($sformatf("rnd%0d_rvalid", n), 64'(bus_rvalid), 64'(m_rvalid));
      chk($sformatf("rnd%0d_err", n),    64'(bus_err),    64'(m_err));
      chk($sformatf("rnd%0d_irq", n),    64'(timer_irq),  64'(m_irq));
      chk($sformatf("rnd%0d_rdata", n),  64'(bus_rdata),  64'(m_rdata));
    end
    idle(1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
